// File: rtl/ac_compressor_driver.sv
// rtl/ac_compressor_driver.sv - sequenced compressor/condenser-fan driver for the ac_cool request
// Optional build macro: AC_RUNTIME_COUNTER_EN (enables the saturating run_time counter)
module ac_compressor_driver #(
  parameter int MIN_ON_CYCLES   = 8,
  parameter int MIN_OFF_CYCLES  = 12,
  parameter int FAN_LEAD_CYCLES = 3,
  parameter int FAN_TAIL_CYCLES = 5,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ac_cool,
  input  logic        fault,
  output logic        compressor_on,
  output logic        fan_on,
  output logic        lockout,
  output logic [2:0]  state,
  output logic [15:0] run_time
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FAN_LEAD = 3'd1,
    RUN      = 3'd2,
    FAN_TAIL = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ON_N   = CNT_W'(MIN_ON_CYCLES);
  localparam logic [CNT_W-1:0] OFF_N  = CNT_W'(MIN_OFF_CYCLES);
  localparam logic [CNT_W-1:0] LEAD_N = CNT_W'(FAN_LEAD_CYCLES);
  localparam logic [CNT_W-1:0] TAIL_N = CNT_W'(FAN_TAIL_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;

  assign state = cur;

  // Next state and dwell counter; a dwell of N leaves on the edge where the counter reads 1
  always_comb begin
    nxt     = cur;
    nxt_cnt = cnt - ONE;
    case (cur)
      IDLE: begin
        nxt_cnt = cnt;
        if (ac_cool && !fault) begin
          nxt     = FAN_LEAD;
          nxt_cnt = LEAD_N;
        end
      end
      FAN_LEAD: begin
        if (fault || !ac_cool) begin
          nxt     = IDLE;
          nxt_cnt = '0;
        end else if (cnt == ONE) begin
          nxt     = RUN;
          nxt_cnt = ON_N;
        end
      end
      RUN: begin
        // Counter parks at 0 once the minimum on-time is served; fault cuts it short
        if (fault || ((cnt <= ONE) && !ac_cool)) begin
          nxt     = FAN_TAIL;
          nxt_cnt = TAIL_N;
        end else if (cnt == '0) begin
          nxt_cnt = '0;
        end
      end
      FAN_TAIL: begin
        if (cnt == ONE) begin
          nxt     = LOCKOUT;
          nxt_cnt = OFF_N;
        end
      end
      LOCKOUT: begin
        if (cnt == ONE) begin
          nxt     = IDLE;
          nxt_cnt = '0;
        end
      end
      default: begin
        nxt     = LOCKOUT;
        nxt_cnt = OFF_N;
      end
    endcase
  end

  // State, dwell counter and drive outputs registered together from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur           <= LOCKOUT;
      cnt           <= OFF_N;
      compressor_on <= 1'b0;
      fan_on        <= 1'b0;
      lockout       <= 1'b1;
    end else begin
      cur           <= nxt;
      cnt           <= nxt_cnt;
      compressor_on <= (nxt == RUN);
      fan_on        <= (nxt == FAN_LEAD) || (nxt == RUN) || (nxt == FAN_TAIL);
      lockout       <= (nxt == LOCKOUT);
    end
  end

`ifdef AC_RUNTIME_COUNTER_EN
  logic [15:0] rt_cnt;

  // Accumulate compressor-on edges, holding at full scale
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rt_cnt <= 16'h0000;
    end else if (compressor_on && (rt_cnt != 16'hFFFF)) begin
      rt_cnt <= rt_cnt + 16'd1;
    end
  end

  assign run_time = rt_cnt;
`else
  assign run_time = 16'h0000;
`endif

endmodule

// File: tb/tb_ac_compressor_driver.sv
// tb/tb_ac_compressor_driver.sv - randomized and directed bench for ac_compressor_driver
module tb_ac_compressor_driver;

  localparam int ON_N   = 8;
  localparam int OFF_N  = 12;
  localparam int LEAD_N = 3;
  localparam int TAIL_N = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        ac_cool;
  logic        fault;
  logic        compressor_on;
  logic        fan_on;
  logic        lockout;
  logic [2:0]  state;
  logic [15:0] run_time;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase name, edges already spent in the phase, run edges seen
  int m_phase;
  int m_spent;
  int m_run;

  ac_compressor_driver dut (
    .clk(clk),
    .reset(reset),
    .ac_cool(ac_cool),
    .fault(fault),
    .compressor_on(compressor_on),
    .fan_on(fan_on),
    .lockout(lockout),
    .state(state),
    .run_time(run_time)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 4;
    m_spent = 0;
    m_run   = 0;
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_spent = 0;
  endtask

  // One clock edge of the behavioural rules
  task automatic model_step();
    int e;
    e = m_spent + 1;
`ifdef AC_RUNTIME_COUNTER_EN
    if (m_phase == 2 && m_run < 65535) m_run++;
`endif
    m_spent = e;
    case (m_phase)
      0: if (ac_cool && !fault) enter(1);
      1: if (!ac_cool || fault) enter(0);
         else if (e >= LEAD_N) enter(2);
      2: if (fault || (e >= ON_N && !ac_cool)) enter(3);
      3: if (e >= TAIL_N) enter(4);
      default: if (e >= OFF_N) enter(0);
    endcase
  endtask

  task automatic check_all();
    check("state", int'(state), m_phase);
    check("compressor_on", int'(compressor_on), (m_phase == 2) ? 1 : 0);
    check("fan_on", int'(fan_on), (m_phase >= 1 && m_phase <= 3) ? 1 : 0);
    check("lockout", int'(lockout), (m_phase == 4) ? 1 : 0);
    check("run_time", int'(run_time), m_run);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Called 1 time unit after an edge: pulse reset between edges and check the immediate response
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_comp", int'(compressor_on), 0);
    check("rst_fan", int'(fan_on), 0);
    check("rst_state", int'(state), 4);
    check("rst_lockout", int'(lockout), 1);
    check("rst_run_time", int'(run_time), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    ac_cool = 1'b1;
    fault   = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1 reset = 1'b0;

    // Power-up with request held
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i == 12) check("pu_idle", int'(state), 0);
      if (i == 13) check("pu_fan", int'(fan_on), 1);
      if (i == 15) check("pu_comp_lo", int'(compressor_on), 0);
      if (i == 16) check("pu_comp_hi", int'(compressor_on), 1);
    end

    // Minimum on-time: request drops after two RUN edges
    cyc();
    cyc();
    ac_cool = 1'b0;
    for (int i = 3; i <= 8; i++) begin
      cyc();
      if (i == 7) check("minon_comp", int'(compressor_on), 1);
      if (i == 8) check("minon_tail", int'(state), 3);
    end
    for (int i = 1; i <= TAIL_N; i++) begin
      cyc();
      if (i == TAIL_N - 1) check("tail_fan", int'(fan_on), 1);
      if (i == TAIL_N) check("tail_lock", int'(state), 4);
    end
    for (int i = 1; i <= OFF_N; i++) cyc();
    check("lock_idle", int'(state), 0);

    // Fault override on the 3rd RUN edge
    ac_cool = 1'b1;
    for (int i = 0; i < 1 + LEAD_N + 2; i++) cyc();
    fault = 1'b1;
    cyc();
    check("flt_state", int'(state), 3);
    check("flt_comp", int'(compressor_on), 0);
    check("flt_fan", int'(fan_on), 1);
    for (int i = 0; i < TAIL_N + OFF_N + 6; i++) cyc();
    check("flt_idle", int'(state), 0);

    // Lead abort on the 2nd FAN_LEAD edge
    fault = 1'b0;
    cyc();
    cyc();
    ac_cool = 1'b0;
    cyc();
    check("abort_state", int'(state), 0);
    check("abort_fan", int'(fan_on), 0);
    check("abort_lock", int'(lockout), 0);
    ac_cool = 1'b1;
    cyc();
    check("abort_relead", int'(state), 1);

    // Async reset mid-RUN, request held afterwards
    for (int i = 0; i < LEAD_N + 2; i++) cyc();
    async_reset();
    for (int i = 1; i <= OFF_N + 1; i++) begin
      cyc();
      if (i == OFF_N - 1) check("rr_lock", int'(state), 4);
    end
    check("rr_lead", int'(state), 1);

`ifdef AC_RUNTIME_COUNTER_EN
    // Two complete minimum RUN periods, then a long run to saturation
    async_reset();
    ac_cool = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < OFF_N + 1 + LEAD_N; i++) cyc();
      ac_cool = 1'b0;
      for (int i = 0; i < ON_N + TAIL_N; i++) cyc();
      ac_cool = 1'b1;
    end
    check("rt_sixteen", int'(run_time), 16);
    for (int i = 0; i < 65600; i++) cyc();
    check("rt_sat", int'(run_time), 65535);
    ac_cool = 1'b0;
    for (int i = 0; i < TAIL_N + OFF_N + 2; i++) cyc();
    check("rt_hold", int'(run_time), 65535);
`endif

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) ac_cool = ~ac_cool;
      if (fault) begin
        if ($urandom_range(0, 5) == 0) fault = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        fault = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) async_reset();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
